// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control types, stage bit indices and FSM states.
package pipe_ctrl_pkg;
  typedef logic [5:0] stall_t;
  typedef logic [31:0] inst_addr_t;
  typedef logic bit_t;
  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;
  localparam int STALL_EX = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB = 5;
  localparam inst_addr_t EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
  typedef enum logic {RUN, POST_FLUSH} pipe_ctrl_state_t;
  // Freeze every stage up to and including top; wb always keeps draining.
  function automatic stall_t stall_upto(int top);
    stall_t s;
    for (int i = 0; i < 6; i++) s[i] = (i <= top) && (i != STALL_WB);
    return s;
  endfunction
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at LIMIT, with synchronous clear.
module sat_counter #(
  parameter int W = 8,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);
  assign sat = count == LIMIT;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (inc && !sat) count <= count + 1'b1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests, drives exception flush/redirect,
// and runs the stall watchdog and stall-cycle perf counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter inst_addr_t EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int TIMEOUT = 1023,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              exc_valid,
  input  logic              exc_eret,
  input  inst_addr_t        cp0_epc,
  output stall_t            stall,
  output bit_t              flush,
  output inst_addr_t        new_pc,
  output logic              watchdog_err,
  output logic [PERF_W-1:0] stall_cycles
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  pipe_ctrl_state_t state, state_d;
  inst_addr_t new_pc_q;
  logic accept, run, wd_sat, err_q, perf_sat;
  logic [WD_W-1:0] wd_count;
  // Outputs are gated by rst so an async reset silences them immediately.
  always_comb begin
    run = state == RUN;
    accept = !rst && run && exc_valid && !stallreq_mem;
    stall = (rst || accept) ? '0 :
            stallreq_mem ? stall_upto(STALL_MEM) :
            (stallreq_ex && run) ? stall_upto(STALL_EX) :
            (stallreq_id && run) ? stall_upto(STALL_ID) :
            stallreq_if ? stall_upto(STALL_IF) : '0;
    flush = accept;
    new_pc = accept ? (exc_eret ? cp0_epc : EXC_VECTOR) : new_pc_q;
    state_d = accept ? POST_FLUSH : RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      new_pc_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) new_pc_q <= new_pc;
      err_q <= err_q | wd_sat;
    end
  assign watchdog_err = err_q | wd_sat;
  sat_counter #(.W(WD_W), .LIMIT(WD_W'(TIMEOUT))) u_watchdog (
    .clk(clk), .rst(rst), .inc(stall[STALL_PC]), .clr(!stall[STALL_PC] || flush),
    .count(wd_count), .sat(wd_sat)
  );
  sat_counter #(.W(PERF_W)) u_perf (
    .clk(clk), .rst(rst), .inc(stall[STALL_PC] && !perf_sat), .clr(1'b0),
    .count(stall_cycles), .sat(perf_sat)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl (TIMEOUT=8, PERF_W=5).
module tb_pipe_ctrl;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int TMO = 8;
  localparam int SC_MAX = 31;
  logic clk = 1'b0, rst = 1'b1;
  logic sif = 0, sid = 0, sex = 0, smem = 0, ev = 0, er = 0;
  logic [31:0] epc = '0;
  logic [5:0] stall;
  logic flush, wd_err;
  logic [31:0] new_pc;
  logic [4:0] sc;
  typedef struct {
    logic [5:0] stall;
    logic flush;
    logic [31:0] npc;
    logic err;
    logic [4:0] sc;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  bit m_pf, m_err;
  int m_wd, m_sc;

  pipe_ctrl #(.TIMEOUT(TMO), .PERF_W(5)) dut (
    .clk(clk), .rst(rst), .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex),
    .stallreq_mem(smem), .exc_valid(ev), .exc_eret(er), .cp0_epc(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .watchdog_err(wd_err),
    .stall_cycles(sc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pf = 0; m_err = 0; m_wd = 0; m_sc = 0;
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_flush"}, 32'(flush), 0);
    chk({tag, "_new_pc"}, new_pc, 0);
    chk({tag, "_wd"}, 32'(wd_err), 0);
    chk({tag, "_sc"}, 32'(sc), 0);
  endtask

  task automatic cyc(input string tag, input logic i_if, i_id, i_ex, i_mem, i_ev, i_er,
                     input logic [31:0] i_epc);
    exp_t e, o;
    logic acc;
    @(negedge clk);
    sif = i_if; sid = i_id; sex = i_ex; smem = i_mem; ev = i_ev; er = i_er; epc = i_epc;
    #1;
    acc = !m_pf && i_ev && !i_mem;
    e.stall = acc ? 6'h00 : i_mem ? 6'h1F : (i_ex && !m_pf) ? 6'h0F :
              (i_id && !m_pf) ? 6'h07 : i_if ? 6'h03 : 6'h00;
    e.flush = acc;
    e.npc = i_er ? i_epc : VEC;
    e.err = m_err;
    e.sc = 5'(m_sc);
    sb.push_back(e);
    o = sb.pop_front();
    chk({tag, "_stall"}, 32'(stall), 32'(o.stall));
    chk({tag, "_flush"}, 32'(flush), 32'(o.flush));
    if (o.flush) chk({tag, "_new_pc"}, new_pc, o.npc);
    chk({tag, "_wd"}, 32'(wd_err), 32'(o.err));
    chk({tag, "_sc"}, 32'(sc), 32'(o.sc));
    @(posedge clk);
    m_wd = o.stall[0] ? (m_wd < TMO ? m_wd + 1 : TMO) : 0;
    if (m_wd == TMO) m_err = 1;
    if (o.stall[0] && m_sc < SC_MAX) m_sc++;
    m_pf = acc;
  endtask

  initial begin
    model_reset();
    #3 rst_check("reset");
    #4 rst = 1'b0;
    cyc("pri_if", 1, 0, 0, 0, 0, 0, 0);
    cyc("pri_id", 0, 1, 0, 0, 0, 0, 0);
    cyc("pri_ex", 0, 0, 1, 0, 0, 0, 0);
    cyc("pri_mem", 0, 0, 0, 1, 0, 0, 0);
    cyc("pri_all", 1, 1, 1, 1, 0, 0, 0);
    cyc("pri_none", 0, 0, 0, 0, 0, 0, 0);
    cyc("exc", 1, 1, 1, 0, 1, 0, 32'h1111_2222);
    cyc("exc_post", 0, 1, 1, 0, 1, 0, 0);
    cyc("exc_idle", 0, 0, 0, 0, 0, 0, 0);
    cyc("eret", 0, 0, 0, 0, 1, 1, 32'h8000_1234);
    cyc("eret_post_if", 1, 0, 0, 0, 1, 1, 32'h8000_1234);
    cyc("eret_idle", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc("defer", 0, 0, 0, 1, 1, 0, 0);
    cyc("defer_acc", 0, 0, 0, 0, 1, 0, 0);
    cyc("defer_post_ex", 0, 0, 1, 0, 0, 0, 0);
    cyc("defer_idle", 0, 0, 0, 0, 0, 0, 0);
    repeat (TMO) cyc("wd_stall", 1, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc("wd_sticky", 0, 0, 0, 0, 0, 0, 0);
    repeat (20) cyc("perf_sat", 0, 0, 0, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1 rst_check("rst_stall");
    #1 rst = 1'b0;
    model_reset();
    cyc("after_rst_exc", 0, 0, 0, 0, 1, 0, 0);
    sif = 1'b1;
    #1 chk("pf_if", 32'(stall), 32'h03);
    #1 rst = 1'b1;
    #1 rst_check("rst_post_flush");
    #1 rst = 1'b0;
    model_reset();
    cyc("after_rst_eret", 0, 0, 0, 0, 1, 1, 32'h1234_5678);
    cyc("final_idle", 0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
